conf_int_mul_seq_apx: RTL and testbench
=======================================

// Module: conf_int_mul_seq_apx
// PURPOSE
//  Parametrised, handshaked, configurable-precision signed multiplier; successor to the fixed-width IDCT multiplier wrapper.
//  Accurate mode: two passes (low half, then high half of A) through one shared half-width multiplier; approx mode: high pass only.
//  Selectable output window per request, with valid/ready on input and output; sits between the IDCT coefficient ROM/datapath and the accumulator.
// PARAMETERS
//  A_W    24  operand A width (signed, even)
//  B_W    12  operand B width (signed)
//  OUT_W  32  result width; P_W = A_W+B_W, SH_MAX = P_W-OUT_W (must be >= 0)
//  SH_W    3  width of in_shift
// PORTS
//  clk        in   1      clock, rising edge
//  rstN       in   1      asynchronous reset, active low
//  in_valid   in   1      request valid
//  in_ready   out  1      request accepted when in_valid & in_ready
//  in_a       in   A_W    signed multiplicand
//  in_b       in   B_W    signed multiplier
//  in_apx     in   1      1 = approximate (A low half treated as 0), 0 = accurate
//  in_shift   in   SH_W   output window LSB; out_p = prod[in_shift +: OUT_W]
//  out_valid  out  1      result valid, held until out_ready
//  out_ready  in   1      consumer accepts result
//  out_p      out  OUT_W  windowed product
//  out_apx    out  1      mode tag of the result
//  busy       out  1      state != ST_IDLE
// BEHAVIOUR
//  - Reset (rstN low, async): state=ST_IDLE, out_valid=0, out_p=0, out_apx=0, acc=0, busy=0; in_ready=1 after release.
//  - H = A_W/2. a_lo = in_a[H-1:0] (unsigned), a_hi = in_a[A_W-1:H] (signed). prod = (a_hi*b)<<H + a_lo*b, P_W bits, signed.
//  - Accept latches a, b, apx, shift (clamped to SH_MAX if larger); the request is not re-sampled afterwards.
//  - FSM: ST_IDLE -accept&!apx-> ST_LO -> ST_HI -> ST_DONE; ST_IDLE -accept&apx-> ST_HI -> ST_DONE.
//    ST_LO: acc <= zext({1'b0,a_lo})*b. ST_HI: acc <= acc + (sext(a_hi)*b << H); approx: acc starts at 0.
//    Entering ST_DONE registers out_p = window(acc), out_valid=1.
//  - Latency accept->out_valid: 3 cycles accurate, 2 cycles approx.
//  - ST_DONE: out_p/out_apx stable while out_valid & !out_ready. On out_ready: out_valid drops unless a new
//    request is accepted the same cycle.
//  - in_ready = (state==ST_IDLE) | (state==ST_DONE & out_ready): back-to-back accepts without a bubble on the input side.
//  - in_valid is ignored when in_ready=0; the mode tag travels with its own result.
//  - Reset mid-operation aborts the request silently; no partial result is ever presented.
//  - Without saturation, the window is a plain slice (upper bits wrap/discard); lower bits below shift are truncated, no rounding.
// CONFIGURATION
//  CONF_MUL_SAT_EN defined: if prod bits above the window are not all equal to the window MSB, out_p saturates to
//    0x7FF..F (positive) or 0x800..0 (negative).
//  CONF_MUL_SAT_EN undefined: plain slice, wrap-around; no saturation logic synthesised.
// STRUCTURE
//  Package conf_mul_pkg: state encoding (ST_IDLE, ST_LO, ST_HI, ST_DONE as 2-bit localparams) and a function for
//    window/saturation.
//  Sub-module conf_int_mul_core: combinational signed (H+1) x B_W multiplier, result H+1+B_W bits, shared by both passes;
//    kept separate so the team can swap in approximate multiplier variants.
// TESTING (A_W=24, B_W=12, OUT_W=32)
//  1 acc: a=0x000123, b=0x005, shift=0 -> out_p=0x000005AF, out_apx=0, out_valid 3 cycles after accept.
//  2 apx: a=0x012345, b=0x002, shift=0 -> out_p=0x00024000, out_apx=1, out_valid 2 cycles after accept.
//  3 signed: a=0xFFFFFF, b=0xFFF acc -> out_p=0x00000001; same operands apx -> out_p=0x00001000.
//  4 backpressure: out_ready=0 for 5 cycles -> out_p stable, in_ready=0; raise out_ready with in_valid=1 ->
//    accept that cycle, next result follows.
//  5 window: a=0x7FFFFF, b=0x7FF acc (prod 0x3FF7FF801): shift=4 -> 0x3FF7FF80;
//    shift=0 -> 0x7FFFFFFF with CONF_MUL_SAT_EN, 0xFF7FF801 without; shift=7 clamps to 4.
//  6 reset: pull rstN low while in ST_LO -> out_valid=0, busy=0 immediately; after release in_ready=1 and no stale result appears.

Source files
------------

// File: rtl/conf_mul_pkg.sv
// Shared types and helpers for the configurable-precision sequential multiplier.
// Holds the FSM state encoding and the saturating output-window function.
package conf_mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // prod is the full product sign-extended to 64 bits; out_w must be below 64.
  function automatic logic [63:0] win_sat(input logic [63:0] prod, input int unsigned sh,
                                          input int unsigned out_w);
    logic signed [63:0] s;
    logic signed [63:0] top;
    logic        [63:0] mask;
    logic        [63:0] r;
    s    = $signed(prod) >>> sh;
    mask = (64'd1 << out_w) - 64'd1;
    // Everything from the window MSB upwards must be a pure sign extension.
    top  = s >>> (out_w - 1);
    if (top == '0 || top == '1) begin
      r = s & mask;
    end else if (s[63]) begin
      r = 64'd1 << (out_w - 1);
    end else begin
      r = mask >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/conf_int_mul_seq_apx_if.sv
// Request/response handshake bundle for conf_int_mul_seq_apx.
// slave is the multiplier side; master is the producer/consumer side.
interface conf_int_mul_seq_apx_if #(
  parameter int unsigned A_W   = 24,
  parameter int unsigned B_W   = 12,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned SH_W  = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [A_W-1:0]   in_a;
  logic [B_W-1:0]   in_b;
  logic             in_apx;
  logic [SH_W-1:0]  in_shift;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_p;
  logic             out_apx;
  logic             busy;

  modport slave (
    input  in_valid, in_a, in_b, in_apx, in_shift, out_ready,
    output in_ready, out_valid, out_p, out_apx, busy
  );

  modport master (
    output in_valid, in_a, in_b, in_apx, in_shift, out_ready,
    input  in_ready, out_valid, out_p, out_apx, busy
  );
endinterface

// File: rtl/conf_int_mul_core.sv
// Combinational signed (H+1) x B_W multiplier shared by the low and high passes.
// Isolated so approximate multiplier variants can be dropped in without touching the FSM.
module conf_int_mul_core #(
  parameter int unsigned H   = 12,
  parameter int unsigned B_W = 12
) (
  input  logic signed [H:0]       a,
  input  logic signed [B_W-1:0]   b,
  output logic signed [H+B_W:0]   p
);
  localparam int unsigned M_W = H + 1 + B_W;

  logic signed [M_W-1:0] a_x;
  logic signed [M_W-1:0] b_x;

  assign a_x = M_W'(a);
  assign b_x = M_W'(b);
  assign p   = a_x * b_x;
endmodule

// File: rtl/conf_int_mul_seq_apx.sv
// Handshaked configurable-precision signed multiplier: two half-width passes (accurate) or high pass
// only (approx), with a selectable output window. Define CONF_MUL_SAT_EN for a saturating window.
module conf_int_mul_seq_apx
  import conf_mul_pkg::*;
#(
  parameter int unsigned A_W   = 24,
  parameter int unsigned B_W   = 12,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned SH_W  = 3
) (
  input logic                    clk,
  input logic                    rstN,
  conf_int_mul_seq_apx_if.slave  bus
);
  localparam int unsigned H      = A_W / 2;
  localparam int unsigned P_W    = A_W + B_W;
  localparam int unsigned SH_MAX = P_W - OUT_W;
  localparam int unsigned M_W    = H + 1 + B_W;

  state_e                  state_q;
  logic signed [A_W-1:0]   a_q;
  logic signed [B_W-1:0]   b_q;
  logic                    apx_q;
  logic [SH_W-1:0]         shift_q;
  logic signed [P_W-1:0]   acc_q;
  logic [OUT_W-1:0]        out_p_q;
  logic                    out_valid_q;
  logic                    out_apx_q;

  logic signed [H:0]       mul_a;
  logic signed [M_W-1:0]   mul_p;
  logic signed [P_W-1:0]   acc_lo;
  logic signed [P_W-1:0]   acc_hi;
  logic [OUT_W-1:0]        win_p;
  logic [SH_W-1:0]         shift_in;
  logic                    in_ready;
  logic                    accept;

  // Low pass feeds a_lo as an unsigned value, high pass feeds a_hi sign-extended.
  always_comb begin
    if (state_q == ST_LO) begin
      mul_a = {1'b0, a_q[H-1:0]};
    end else begin
      mul_a = {a_q[A_W-1], a_q[A_W-1:H]};
    end
  end

  conf_int_mul_core #(
    .H   (H),
    .B_W (B_W)
  ) u_core (
    .a (mul_a),
    .b (b_q),
    .p (mul_p)
  );

  assign acc_lo = P_W'(mul_p);
  assign acc_hi = acc_q + (P_W'(mul_p) << H);

`ifdef CONF_MUL_SAT_EN
  assign win_p = OUT_W'(win_sat(64'(acc_hi), 32'(shift_q), OUT_W));
`else
  // Plain slice: bits above the window are discarded, bits below are truncated.
  assign win_p = OUT_W'(acc_hi >> shift_q);
`endif

  assign shift_in = (32'(bus.in_shift) > SH_MAX) ? SH_W'(SH_MAX) : bus.in_shift;
  assign in_ready = (state_q == ST_IDLE) | ((state_q == ST_DONE) & bus.out_ready);
  assign accept   = bus.in_valid & in_ready;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      apx_q       <= 1'b0;
      shift_q     <= '0;
      acc_q       <= '0;
      out_p_q     <= '0;
      out_valid_q <= 1'b0;
      out_apx_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if ((state_q == ST_DONE) && bus.out_ready) begin
            out_valid_q <= 1'b0;
          end
          if (accept) begin
            a_q     <= bus.in_a;
            b_q     <= bus.in_b;
            apx_q   <= bus.in_apx;
            shift_q <= shift_in;
            acc_q   <= '0;
            state_q <= bus.in_apx ? ST_HI : ST_LO;
          end else if ((state_q == ST_DONE) && bus.out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        ST_LO: begin
          acc_q   <= acc_lo;
          state_q <= ST_HI;
        end
        ST_HI: begin
          acc_q       <= acc_hi;
          out_p_q     <= win_p;
          out_apx_q   <= apx_q;
          out_valid_q <= 1'b1;
          state_q     <= ST_DONE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_p     = out_p_q;
  assign bus.out_apx   = out_apx_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_conf_int_mul_seq_apx.sv
// Scoreboard bench for conf_int_mul_seq_apx: directed requests push expected results,
// a negedge monitor pops and compares whenever a result is handed over.
module tb_conf_int_mul_seq_apx;
  localparam int unsigned A_W   = 24;
  localparam int unsigned B_W   = 12;
  localparam int unsigned OUT_W = 32;
  localparam int unsigned SH_W  = 3;

  typedef struct {
    logic [31:0] p;
    logic        apx;
    int          acc_cyc;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   seen = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conf_int_mul_seq_apx_if #(.A_W(A_W), .B_W(B_W), .OUT_W(OUT_W), .SH_W(SH_W)) ifc ();

  conf_int_mul_seq_apx #(.A_W(A_W), .B_W(B_W), .OUT_W(OUT_W), .SH_W(SH_W)) dut (
    .clk  (clk),
    .rstN (rst_n),
    .bus  (ifc.slave)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: latency on first sight of a result, value and tag on handover.
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else if (ifc.out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 64'd1, 64'd0);
      end else begin
        if (!seen) begin
          seen = 1'b1;
          check("latency", 64'(cyc - exp_q[0].acc_cyc), 64'(exp_q[0].lat));
        end
        if (ifc.out_ready) begin
          check("out_p", 64'(ifc.out_p), 64'(exp_q[0].p));
          check("out_apx", 64'(ifc.out_apx), 64'(exp_q[0].apx));
          void'(exp_q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [23:0] a, input logic [11:0] b, input logic apx,
                      input logic [2:0] sh, input logic [31:0] ep, input int lat,
                      output int waited);
    exp_t e;
    waited = 0;
    @(posedge clk);
    #1;
    ifc.in_valid  = 1'b1;
    ifc.in_a      = a;
    ifc.in_b      = b;
    ifc.in_apx    = apx;
    ifc.in_shift  = sh;
    ifc.out_ready = 1'b1;
    @(negedge clk);
    while (!ifc.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!ifc.in_ready) begin
      check("accept_timeout", 64'd0, 64'd1);
      ifc.in_valid = 1'b0;
      return;
    end
    e.p = ep;
    e.apx = apx;
    e.acc_cyc = cyc;
    e.lat = lat;
    @(posedge clk);
    exp_q.push_back(e);
    #1;
    ifc.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    int stale;
    logic [31:0] sat_exp;
`ifdef CONF_MUL_SAT_EN
    sat_exp = 32'h7FFF_FFFF;
`else
    sat_exp = 32'hFF7F_F801;
`endif
    ifc.in_valid  = 1'b0;
    ifc.in_a      = '0;
    ifc.in_b      = '0;
    ifc.in_apx    = 1'b0;
    ifc.in_shift  = '0;
    ifc.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(ifc.out_valid), 64'd0);
    check("rst_out_p", 64'(ifc.out_p), 64'd0);
    check("rst_out_apx", 64'(ifc.out_apx), 64'd0);
    check("rst_busy", 64'(ifc.busy), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 64'(ifc.in_ready), 64'd1);

    // Basic accurate / approximate / signed cases.
    send(24'h000123, 12'h005, 1'b0, 3'd0, 32'h0000_05AF, 3, w);
    drain();
    send(24'h012345, 12'h002, 1'b1, 3'd0, 32'h0002_4000, 2, w);
    drain();
    send(24'hFFFFFF, 12'hFFF, 1'b0, 3'd0, 32'h0000_0001, 3, w);
    send(24'hFFFFFF, 12'hFFF, 1'b1, 3'd0, 32'h0000_1000, 2, w);
    drain();

    // Backpressure: result must hold while out_ready is low, then hand over with a new accept.
    send(24'h000123, 12'h005, 1'b0, 3'd0, 32'h0000_05AF, 3, w);
    ifc.out_ready = 1'b0;
    w = 0;
    @(negedge clk);
    while (!ifc.out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("bp_out_valid_seen", 64'(ifc.out_valid), 64'd1);
    repeat (5) begin
      @(negedge clk);
      check("bp_out_valid", 64'(ifc.out_valid), 64'd1);
      check("bp_out_p", 64'(ifc.out_p), 64'h05AF);
      check("bp_in_ready", 64'(ifc.in_ready), 64'd0);
    end
    send(24'h012345, 12'h002, 1'b1, 3'd0, 32'h0002_4000, 2, w);
    check("bp_accept_same_cycle", 64'(w), 64'd0);
    drain();

    // Output window and shift clamping.
    send(24'h7FFFFF, 12'h7FF, 1'b0, 3'd4, 32'h3FF7_FF80, 3, w);
    send(24'h7FFFFF, 12'h7FF, 1'b0, 3'd0, sat_exp, 3, w);
    send(24'h7FFFFF, 12'h7FF, 1'b0, 3'd7, 32'h3FF7_FF80, 3, w);
    drain();

    // Reset while in the low pass aborts silently.
    send(24'h000123, 12'h005, 1'b0, 3'd0, 32'h0000_05AF, 3, w);
    check("mid_busy", 64'(ifc.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(ifc.out_valid), 64'd0);
    check("mid_rst_busy", 64'(ifc.busy), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 64'(ifc.in_ready), 64'd1);
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (ifc.out_valid) stale++;
    end
    check("no_stale_result", 64'(stale), 64'd0);
    send(24'h012345, 12'h002, 1'b1, 3'd0, 32'h0002_4000, 2, w);
    drain();

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
